// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU fetch/decode path.
// Holds sequencer state encoding, datapath widths, the halt opcode and the
// instruction field positions (opcode in the upper nibble, operand in the lower).
package cpu_pkg;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;
  localparam int CTRL_W  = 11;
  localparam logic [3:0] HALT_OP = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPR_MSB = 3;
  localparam int OPR_LSB = 0;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, HALTED, HOLD} state_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Ports:
//   clk, rst  : clock, async active-high reset (pc -> 0)
//   load      : load load_val (takes priority over inc)
//   inc       : increment, wrapping modulo 2**PC_W
//   load_val  : jump target
//   pc        : current program counter
module pc_reg #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_W'(1);  // natural wrap at all-ones
  end
endmodule

// File: rtl/opcode_sequencer.sv
// Fetch/decode sequencer feeding the 16:1 control-word mux.
// Fetches an instruction over rom_req/rom_ack, drives the opcode onto the mux
// selects, registers the returned control word and presents it to the
// datapath with ctrl_valid until exec_done.
// Ports:
//   clk, rst            : clock, async active-high reset
//   rom_addr/req/ack/data : program ROM fetch handshake (rom_addr = pc)
//   sel3..sel0          : mux select = opcode (sel3 is MSB)
//   ctrl_in             : mux result (combinational return)
//   ctrl_word, operand  : registered control word / operand, qualified by ctrl_valid
//   exec_done, jmp_take : datapath completion; jump to operand when both high
//   halted              : sticky, set by the halt opcode, cleared only by rst
//   step                : single-step advance (only with SINGLE_STEP_EN)
// Build option: define SINGLE_STEP_EN to gate every fetch on a sampled step=1.
module opcode_sequencer #(
  parameter int         PC_W    = cpu_pkg::PC_W,
  parameter int         INSTR_W = cpu_pkg::INSTR_W,
  parameter int         CTRL_W  = cpu_pkg::CTRL_W,
  parameter logic [3:0] HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               sel3,
  output logic               sel2,
  output logic               sel1,
  output logic               sel0,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic [CTRL_W-1:0]  ctrl_word,
  output logic               ctrl_valid,
  output logic [3:0]         operand,
  input  logic               exec_done,
  input  logic               jmp_take,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               halted
);
  import cpu_pkg::*;

`ifdef SINGLE_STEP_EN
  localparam state_t RST_STATE  = HOLD;
  localparam state_t AFTER_EXEC = HOLD;
`else
  localparam state_t RST_STATE  = FETCH;
  localparam state_t AFTER_EXEC = FETCH;
`endif

  state_t          state, state_nx;
  logic [3:0]      sel;
  logic [PC_W-1:0] pc;
  logic            ack_ok, halt_dec, pc_load, pc_inc;

  // An ack only counts against a request we actually have on the bus.
  assign ack_ok   = (state == FETCH) && rom_req && rom_ack;
  // sel holds the latched opcode, so decode looks at it directly.
  assign halt_dec = (sel == HALT_OP);

  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    case (state)
      HOLD: begin
`ifdef SINGLE_STEP_EN
        if (step) state_nx = FETCH;
`else
        state_nx = FETCH;
`endif
      end
      FETCH:   if (ack_ok) state_nx = DECODE;
      DECODE:  state_nx = halt_dec ? HALTED : EXECUTE;
      EXECUTE: if (exec_done) begin
        state_nx = AFTER_EXEC;
        pc_load  = jmp_take;
        pc_inc   = !jmp_take;
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = RST_STATE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_STATE;
      rom_req    <= 1'b0;
      sel        <= '0;
      operand    <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nx;
      rom_req    <= (state_nx == FETCH);
      ctrl_valid <= (state_nx == EXECUTE);
      halted     <= (state_nx == HALTED);
      if (ack_ok) begin
        sel     <= rom_data[OPC_MSB:OPC_LSB];
        operand <= rom_data[OPR_MSB:OPR_LSB];
      end
      if (state == DECODE && !halt_dec) ctrl_word <= ctrl_in;
    end
  end

  pc_reg #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (PC_W'(operand)),
    .pc       (pc)
  );

  assign rom_addr = pc;
  assign {sel3, sel2, sel1, sel0} = sel;
endmodule
